// File: rtl/counter_compare_pipe.sv
// Up/down counter (clear, load, wrap or saturate) feeding a split-half magnitude comparator.
// Counter/OV: 1 cycle; gt/eq: STAGES cycles after the count; no backpressure, one compare per cycle.
module counter_compare_pipe #(
    parameter int WIDTH    = 16,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             EN,
    input  logic             CLR,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] counter,
    output logic             OV,
    output logic             gt,
    output logic             eq,
    output logic             cmp_valid
);

    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0]  cnt_nxt;
    logic              ov_nxt;
    logic              hi_gt, hi_eq, lo_gt, lo_eq;
    logic [STAGES-2:0] gt_pipe, eq_pipe;
    logic [STAGES-1:0] vld_sr;

    always_comb begin
        cnt_nxt = counter;
        ov_nxt  = 1'b0;
        if (CLR) begin
            cnt_nxt = '0;
        end else if (LD) begin
            cnt_nxt = ld_val;
        end else if (EN) begin
            if (UP) begin
                if (counter == MAX_VAL) begin
                    ov_nxt  = 1'b1;
                    cnt_nxt = (SATURATE != 0) ? MAX_VAL : '0;
                end else begin
                    cnt_nxt = counter + ONE;
                end
            end else begin
                if (counter == '0) begin
                    ov_nxt  = 1'b1;
                    cnt_nxt = (SATURATE != 0) ? '0 : MAX_VAL;
                end else begin
                    cnt_nxt = counter - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            counter <= '0;
            OV      <= 1'b0;
        end else begin
            counter <= cnt_nxt;
            OV      <= ov_nxt;
        end
    end

    // Splitting the compare in halves keeps each stage to a WIDTH/2-bit carry chain.
    always_ff @(posedge clk) begin
        if (Reset) begin
            hi_gt <= 1'b0;
            hi_eq <= 1'b0;
            lo_gt <= 1'b0;
            lo_eq <= 1'b0;
        end else begin
            hi_gt <= counter[WIDTH-1:H] >  cmp_val[WIDTH-1:H];
            hi_eq <= counter[WIDTH-1:H] == cmp_val[WIDTH-1:H];
            lo_gt <= counter[H-1:0]     >  cmp_val[H-1:0];
            lo_eq <= counter[H-1:0]     == cmp_val[H-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            gt_pipe <= '0;
            eq_pipe <= '0;
            vld_sr  <= '0;
        end else begin
            gt_pipe[0] <= hi_gt | (hi_eq & lo_gt);
            eq_pipe[0] <= hi_eq & lo_eq;
            for (int i = 1; i < STAGES - 1; i++) begin
                gt_pipe[i] <= gt_pipe[i-1];
                eq_pipe[i] <= eq_pipe[i-1];
            end
            vld_sr <= {vld_sr[STAGES-2:0], 1'b1};
        end
    end

    assign gt        = gt_pipe[STAGES-2];
    assign eq        = eq_pipe[STAGES-2];
    assign cmp_valid = vld_sr[STAGES-1];

endmodule

// File: tb/tb_counter_compare_pipe.sv
// Drives three configurations (wrap/2-stage, saturate/2-stage, wrap/4-stage) with shared stimulus;
// a reference model predicts counts and a per-instance queue holds pending compare results.
module tb_counter_compare_pipe;

    logic        clk = 1'b0;
    logic        Reset, EN, CLR, UP, LD;
    logic [15:0] ld_val, cmp_val;

    logic [15:0] o_cnt [3];
    logic        o_ov  [3];
    logic        o_gt  [3];
    logic        o_eq  [3];
    logic        o_v   [3];

    logic [15:0] m_cnt [3];
    logic        m_ov  [3];
    logic [1:0]  sbq   [3][$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_compare_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(0)) u_wrap (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .UP(UP), .LD(LD),
        .ld_val(ld_val), .cmp_val(cmp_val), .counter(o_cnt[0]), .OV(o_ov[0]),
        .gt(o_gt[0]), .eq(o_eq[0]), .cmp_valid(o_v[0]));

    counter_compare_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1)) u_sat (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .UP(UP), .LD(LD),
        .ld_val(ld_val), .cmp_val(cmp_val), .counter(o_cnt[1]), .OV(o_ov[1]),
        .gt(o_gt[1]), .eq(o_eq[1]), .cmp_valid(o_v[1]));

    counter_compare_pipe #(.WIDTH(16), .STAGES(4), .SATURATE(0)) u_deep (
        .clk(clk), .Reset(Reset), .EN(EN), .CLR(CLR), .UP(UP), .LD(LD),
        .ld_val(ld_val), .cmp_val(cmp_val), .counter(o_cnt[2]), .OV(o_ov[2]),
        .gt(o_gt[2]), .eq(o_eq[2]), .cmp_valid(o_v[2]));

    function automatic int stg(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Integer-domain reference: out-of-range results signal a bound crossing.
    task automatic model_step(input int i);
        int nx;
        if (Reset) begin
            m_cnt[i] = '0;
            m_ov[i]  = 1'b0;
        end else begin
            m_ov[i] = 1'b0;
            if (CLR) m_cnt[i] = '0;
            else if (LD) m_cnt[i] = ld_val;
            else if (EN) begin
                nx = int'(m_cnt[i]) + (UP ? 1 : -1);
                if (nx > 65535 || nx < 0) begin
                    m_ov[i] = 1'b1;
                    if (i == 1) nx = (nx < 0) ? 0 : 65535;
                    else        nx = nx & 32'hFFFF;
                end
                m_cnt[i] = nx[15:0];
            end
        end
    endtask

    task automatic tick();
        logic       rst_e;
        logic [1:0] e;
        rst_e = Reset;
        for (int i = 0; i < 3; i++) begin
            if (Reset) sbq[i].delete();
            else sbq[i].push_back({m_cnt[i] > cmp_val, m_cnt[i] == cmp_val});
            model_step(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cnt[%0d]", i), 32'(o_cnt[i]), 32'(m_cnt[i]));
            chk($sformatf("ov[%0d]", i), 32'(o_ov[i]), 32'(m_ov[i]));
            if (!rst_e && sbq[i].size() == stg(i)) begin
                e = sbq[i].pop_front();
                chk($sformatf("gt[%0d]", i), 32'(o_gt[i]), 32'(e[1]));
                chk($sformatf("eq[%0d]", i), 32'(o_eq[i]), 32'(e[0]));
                chk($sformatf("vld[%0d]", i), 32'(o_v[i]), 32'd1);
            end else begin
                chk($sformatf("gt_idle[%0d]", i), 32'(o_gt[i]), 32'd0);
                chk($sformatf("eq_idle[%0d]", i), 32'(o_eq[i]), 32'd0);
                chk($sformatf("vld_idle[%0d]", i), 32'(o_v[i]), 32'd0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = '0;
            m_ov[i]  = 1'b0;
        end
        Reset = 1'b1; EN = 1'b1; UP = 1'b1; CLR = 1'b0; LD = 1'b0;
        ld_val = '0; cmp_val = '0;

        // Reset held, then counting up after release
        repeat (3) begin
            tick();
            chk("rst_cnt", 32'(o_cnt[0]), 32'h0);
        end
        Reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("rel_cnt", 32'(o_cnt[0]), 32'(k));
            chk("rel_vld2", 32'(o_v[0]), 32'(k >= 2));
            chk("rel_vld4", 32'(o_v[2]), 32'(k >= 4));
        end

        // Wrap up across all-ones, then down across zero
        EN = 1'b0; LD = 1'b1; ld_val = 16'hFFFE; tick();
        LD = 1'b0; EN = 1'b1; UP = 1'b1;
        tick(); chk("wrap_up0", 32'(o_cnt[0]), 32'hFFFF); chk("wrap_ov0", 32'(o_ov[0]), 32'd0);
        tick(); chk("wrap_up1", 32'(o_cnt[0]), 32'h0000); chk("wrap_ov1", 32'(o_ov[0]), 32'd1);
        chk("sat_hold", 32'(o_cnt[1]), 32'hFFFF); chk("sat_ov", 32'(o_ov[1]), 32'd1);
        tick(); chk("wrap_up2", 32'(o_cnt[0]), 32'h0001); chk("wrap_ov2", 32'(o_ov[0]), 32'd0);
        UP = 1'b0;
        tick(); chk("wrap_dn0", 32'(o_cnt[0]), 32'h0000); chk("wrap_dov0", 32'(o_ov[0]), 32'd0);
        tick(); chk("wrap_dn1", 32'(o_cnt[0]), 32'hFFFF); chk("wrap_dov1", 32'(o_ov[0]), 32'd1);
        tick(); chk("wrap_dn2", 32'(o_cnt[0]), 32'hFFFE); chk("wrap_dov2", 32'(o_ov[0]), 32'd0);

        // Saturation at the top, then at zero
        EN = 1'b0; LD = 1'b1; ld_val = 16'hFFFE; tick();
        LD = 1'b0; EN = 1'b1; UP = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sat_top", 32'(o_cnt[1]), 32'hFFFF);
            chk("sat_top_ov", 32'(o_ov[1]), 32'(k != 0));
        end
        EN = 1'b0; CLR = 1'b1; tick();
        chk("clr_no_ov", 32'(o_ov[1]), 32'd0);
        CLR = 1'b0; EN = 1'b1; UP = 1'b0;
        repeat (3) begin
            tick();
            chk("sat_bot", 32'(o_cnt[1]), 32'h0000);
            chk("sat_bot_ov", 32'(o_ov[1]), 32'd1);
        end

        // Compare pipeline around threshold 0105
        cmp_val = 16'h0105; EN = 1'b0; LD = 1'b1; ld_val = 16'h0103; tick();
        LD = 1'b0; EN = 1'b1; UP = 1'b1;
        tick(); tick();
        chk("cmp_at", 32'(o_cnt[0]), 32'h0105);
        tick(); tick();
        chk("cmp_eq", 32'(o_eq[0]), 32'd1); chk("cmp_eq_gt", 32'(o_gt[0]), 32'd0);
        tick();
        chk("cmp_gt", 32'(o_gt[0]), 32'd1); chk("cmp_gt_eq", 32'(o_eq[0]), 32'd0);

        // Half boundary: upper halves differ, lower half of counter is smaller
        cmp_val = 16'h00FF; EN = 1'b0; LD = 1'b1; ld_val = 16'h0100; tick();
        LD = 1'b0; tick(); tick();
        chk("half_gt", 32'(o_gt[0]), 32'd1); chk("half_eq", 32'(o_eq[0]), 32'd0);

        // Priority: CLR beats LD and EN; LD beats EN at the wrap point
        LD = 1'b1; ld_val = 16'h0010; tick();
        CLR = 1'b1; LD = 1'b1; ld_val = 16'h1234; EN = 1'b1; UP = 1'b1; tick();
        chk("pri_clr", 32'(o_cnt[0]), 32'h0); chk("pri_clr_ov", 32'(o_ov[0]), 32'd0);
        CLR = 1'b0; EN = 1'b0; ld_val = 16'hFFFF; tick();
        EN = 1'b1; ld_val = 16'h1234; tick();
        chk("pri_ld", 32'(o_cnt[0]), 32'h1234); chk("pri_ld_ov", 32'(o_ov[0]), 32'd0);

        // Deep pipeline: eq lags four cycles, then mid-run reset
        LD = 1'b1; EN = 1'b0; ld_val = 16'h0020; cmp_val = 16'h0022; tick();
        LD = 1'b0; EN = 1'b1; UP = 1'b1;
        tick(); tick();
        chk("deep_at", 32'(o_cnt[2]), 32'h0022);
        repeat (4) tick();
        chk("deep_eq", 32'(o_eq[2]), 32'd1);
        tick();
        chk("deep_gt", 32'(o_gt[2]), 32'd1);
        Reset = 1'b1; tick();
        chk("mid_rst_cnt", 32'(o_cnt[2]), 32'h0);
        chk("mid_rst_gt", 32'(o_gt[2]), 32'd0);
        chk("mid_rst_vld", 32'(o_v[2]), 32'd0);
        Reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("rerise_vld4", 32'(o_v[2]), 32'(k >= 4));
        end

        // Randomised traffic checked purely by the model and scoreboard
        for (int k = 0; k < 200; k++) begin
            CLR    = ($urandom_range(0, 15) == 0);
            LD     = ($urandom_range(0, 7) == 0);
            EN     = ($urandom_range(0, 3) != 0);
            UP     = $urandom_range(0, 1) == 1;
            ld_val = ($urandom_range(0, 1) == 1) ? 16'hFFFE : 16'($urandom);
            cmp_val = ($urandom_range(0, 2) == 0) ? m_cnt[0] : 16'($urandom);
            Reset  = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
